ntt_addr_gen_param: RTL and testbench
=====================================

// Module: ntt_addr_gen_param
// PURPOSE
// - Parametrised address/twiddle generator for the NTT datapath: N = 2**LOGN points, 4 memory addresses + 1 twiddle index per issue (two radix-2 butterflies).
// - Sequences every pass of NTT (decreasing stride) or INTT (increasing stride), plus linear IN/OUT load/unload.
// - Sits between the top controller (start/done) and the butterfly unit / coefficient RAMs. Valid/ready flow control replaces the fixed wait counters.
// PARAMETERS
// - LOGN       8   log2 of transform size; legal range 3..12
// - ISSUE_GAP 14   idle cycles inserted after each accepted issue (butterfly occupancy); 0 = back-to-back
// - PASS_GAP   4   idle cycles between the last issue of one pass and the first of the next (pipeline drain)
// PORTS
// - clk        in   1       clock
// - rst        in   1       synchronous active-high reset
// - start      in   1       one-cycle pulse; accepted only in IDLE
// - mode       in   2       00 NTT, 01 INTT, 10 IN, 11 OUT; sampled at accepted start
// - addr_ready in   1       consumer accepts current issue when high with addr_valid
// - addr_valid out  1       issue outputs valid
// - radda1     out  LOGN    address a1 = base
// - radda2     out  LOGN    address a2 = base + d
// - raddb1     out  LOGN    address b1 = base + 2d
// - raddb2     out  LOGN    address b2 = base + 3d
// - tf_addr    out  LOGN-1  twiddle ROM index
// - pass_idx   out  4       current pass, 0-based
// - pass_end   out  1       high with the final accepted issue of a pass
// - busy       out  1       high from cycle after accepted start through done cycle
// - done       out  1       one-cycle pulse after the final issue of the operation
// BEHAVIOUR
// - Reset: all outputs 0, FSM IDLE, all counters 0. Reset mid-operation aborts immediately; no done pulse.
// - FSM: IDLE -start-> ISSUE; ISSUE -xfer, not last-of-pass-> GAP (ISSUE_GAP cycles, skipped if 0) -> ISSUE;
//   ISSUE -xfer, last-of-pass, more passes-> DRAIN (PASS_GAP cycles) -> ISSUE; ISSUE -xfer, last issue of last pass-> DONE -> IDLE.
// - xfer = addr_valid & addr_ready. addr_valid high only in ISSUE; outputs held stable while addr_valid & !addr_ready.
// - Latency: addr_valid rises the cycle after accepted start. done asserted in the DONE cycle (cycle after last xfer); busy drops next.
// - start while busy ignored; mode changes while busy ignored.
// - Issue index i = 0..N/4-1 per pass. NTT/INTT: LOGN-1 passes. IN/OUT: 1 pass.
// - NTT pass p: d = (N/4)>>p, G = 2**p groups; INTT pass p: d = 1<<p, G = N/(4d).
// - g = i / d, base = g*4d + (i mod d); all arithmetic in LOGN bits, never overflows (base+3d <= N-1).
// - tf_addr: NTT = G + g; INTT = 2G - 1 - g; IN/OUT = 0.
// - IN/OUT: base = 4i, d = 1 (consecutive words), tf_addr = 0, pass_idx = 0.
// - All outputs registered; division/mod by d implemented as shift/mask (d power of two).
// - pass_end asserted on the xfer cycle of i = N/4-1 in every pass, including the final one.
// STRUCTURE
// - Shared package ntt_pkg: mode encodings (MODE_NTT, MODE_INTT, MODE_IN, MODE_OUT), FSM state enum, LOGN-derived width constants.
// - One sub-module ntt_addr_calc: combinational (mode, pass, i) -> four addresses + tf_addr; top holds FSM, issue/gap/pass counters, output regs.
// TESTING (LOGN=8, ISSUE_GAP=0, PASS_GAP=4 unless stated; addr_ready=1)
// - NTT start -> first issue 0,64,128,192 tf=1; pass 1 issue i=32 -> 128,160,192,224 tf=3; 7 passes x 64 issues, done once.
// - INTT start -> pass 0 i=0: 0,1,2,3 tf=127; i=1: 4,5,6,7 tf=126; pass 6 i=63: 63,127,191,255 tf=1, then done.
// - IN mode -> 64 issues, last 252,253,254,255 tf=0 with pass_end=1; done next cycle; no DRAIN.
// - ISSUE_GAP=14, addr_ready toggled randomly -> exactly 14 idle cycles after each xfer; outputs stable while stalled; 4 idle cycles between passes.
// - start pulsed while busy with mode=INTT -> ignored, NTT sequence unchanged.
// - rst asserted mid-pass 3 -> next cycle all outputs 0, IDLE; new start restarts at pass 0 i=0.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT address generator: mode encodings, FSM states and
// counter widths.
package ntt_pkg;

    localparam logic [1:0] MODE_NTT  = 2'b00;
    localparam logic [1:0] MODE_INTT = 2'b01;
    localparam logic [1:0] MODE_IN   = 2'b10;
    localparam logic [1:0] MODE_OUT  = 2'b11;

    // Pass index width covers LOGN-1 passes for LOGN up to 12
    localparam int unsigned PASS_W = 4;
    localparam int unsigned GAP_W  = 16;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StGap,
        StDrain,
        StDone
    } state_e;

endpackage

// File: rtl/ntt_addr_calc.sv
// Combinational mapping (mode, pass, issue index) -> four butterfly addresses and the
// twiddle ROM index. Stride and group count are powers of two, so div/mod become shift/mask.
module ntt_addr_calc
    import ntt_pkg::*;
#(
    parameter int unsigned LOGN = 8
) (
    input  logic [1:0]        mode,
    input  logic [PASS_W-1:0] pass,
    input  logic [LOGN-3:0]   idx,
    output logic [LOGN-1:0]   a1,
    output logic [LOGN-1:0]   a2,
    output logic [LOGN-1:0]   b1,
    output logic [LOGN-1:0]   b2,
    output logic [LOGN-2:0]   tf
);

    logic [PASS_W-1:0] d_sh;
    logic [PASS_W-1:0] g_sh;
    logic [LOGN-3:0]   grp;
    logic [LOGN-3:0]   rem;
    logic [LOGN-2:0]   grp_cnt;
    logic [LOGN-1:0]   base;
    logic [LOGN-1:0]   d;

    always_comb begin
        // d_sh = log2(stride), g_sh = log2(group count)
        if (mode == MODE_NTT) begin
            d_sh = PASS_W'(LOGN - 2) - pass;
            g_sh = pass;
        end else begin
            d_sh = pass;
            g_sh = PASS_W'(LOGN - 2) - pass;
        end

        grp     = idx >> d_sh;
        rem     = idx & ~({(LOGN - 2){1'b1}} << d_sh);
        grp_cnt = (LOGN - 1)'(1) << g_sh;

        if (mode == MODE_IN || mode == MODE_OUT) begin
            base = {idx, 2'b00};
            d    = LOGN'(1);
            tf   = '0;
        end else begin
            base = (LOGN'(grp) << (d_sh + PASS_W'(2))) | LOGN'(rem);
            d    = LOGN'(1) << d_sh;
            if (mode == MODE_NTT) begin
                tf = grp_cnt + (LOGN - 1)'(grp);
            end else begin
                // 2G can wrap to zero at pass 0; the modular result is still 2G-1-g
                tf = (grp_cnt << 1) - (LOGN - 1)'(1) - (LOGN - 1)'(grp);
            end
        end

        a1 = base;
        a2 = base + d;
        b1 = base + (d << 1);
        b2 = base + (d << 1) + d;
    end

endmodule

// File: rtl/ntt_addr_gen_param.sv
// NTT/INTT address and twiddle sequencer with valid/ready issue handshake, per-issue
// occupancy gaps and inter-pass drain gaps.
module ntt_addr_gen_param
    import ntt_pkg::*;
#(
    parameter int unsigned LOGN      = 8,
    parameter int unsigned ISSUE_GAP = 14,
    parameter int unsigned PASS_GAP  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              addr_ready,
    output logic              addr_valid,
    output logic [LOGN-1:0]   radda1,
    output logic [LOGN-1:0]   radda2,
    output logic [LOGN-1:0]   raddb1,
    output logic [LOGN-1:0]   raddb2,
    output logic [LOGN-2:0]   tf_addr,
    output logic [PASS_W-1:0] pass_idx,
    output logic              pass_end,
    output logic              busy,
    output logic              done
);

    localparam int unsigned    IW     = LOGN - 2;
    localparam logic [IW-1:0]  I_LAST = '1;

    state_e            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [PASS_W-1:0] pass_q, pass_d;
    logic [IW-1:0]     i_q, i_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              xfer;
    logic              last_pass;

    logic [LOGN-1:0]   c_a1, c_a2, c_b1, c_b2;
    logic [LOGN-2:0]   c_tf;

    logic              valid_d, pass_end_d, busy_d, done_d;
    logic [LOGN-1:0]   a1_d, a2_d, b1_d, b2_d;
    logic [LOGN-2:0]   tf_d;

    assign xfer      = addr_valid & addr_ready;
    assign last_pass = (mode_q == MODE_NTT || mode_q == MODE_INTT) ?
                       (pass_q == PASS_W'(LOGN - 2)) : (pass_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            mode_q  <= '0;
            pass_q  <= '0;
            i_q     <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            pass_q  <= pass_d;
            i_q     <= i_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        pass_d  = pass_q;
        i_d     = i_q;
        gap_d   = gap_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StIssue;
                    mode_d  = mode;
                    pass_d  = '0;
                    i_d     = '0;
                end
            end
            StIssue: begin
                if (xfer) begin
                    if (i_q != I_LAST) begin
                        i_d = i_q + IW'(1);
                        if (ISSUE_GAP != 0) begin
                            state_d = StGap;
                            gap_d   = GAP_W'(ISSUE_GAP - 1);
                        end
                    end else if (last_pass) begin
                        state_d = StDone;
                        i_d     = '0;
                        pass_d  = '0;
                    end else begin
                        i_d    = '0;
                        pass_d = pass_q + PASS_W'(1);
                        if (PASS_GAP != 0) begin
                            state_d = StDrain;
                            gap_d   = GAP_W'(PASS_GAP - 1);
                        end
                    end
                end
            end
            StGap, StDrain: begin
                if (gap_q == '0) begin
                    state_d = StIssue;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Addresses are computed for the next issue so they register alongside addr_valid
    ntt_addr_calc #(
        .LOGN (LOGN)
    ) u_calc (
        .mode (mode_d),
        .pass (pass_d),
        .idx  (i_d),
        .a1   (c_a1),
        .a2   (c_a2),
        .b1   (c_b1),
        .b2   (c_b2),
        .tf   (c_tf)
    );

    always_comb begin
        valid_d    = (state_d == StIssue);
        pass_end_d = (state_d == StIssue) && (i_d == I_LAST);
        busy_d     = (state_d != StIdle);
        done_d     = (state_d == StDone);
        a1_d       = radda1;
        a2_d       = radda2;
        b1_d       = raddb1;
        b2_d       = raddb2;
        tf_d       = tf_addr;
        if (state_d == StIssue) begin
            a1_d = c_a1;
            a2_d = c_a2;
            b1_d = c_b1;
            b2_d = c_b2;
            tf_d = c_tf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_valid <= 1'b0;
            radda1     <= '0;
            radda2     <= '0;
            raddb1     <= '0;
            raddb2     <= '0;
            tf_addr    <= '0;
            pass_idx   <= '0;
            pass_end   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            addr_valid <= valid_d;
            radda1     <= a1_d;
            radda2     <= a2_d;
            raddb1     <= b1_d;
            raddb2     <= b2_d;
            tf_addr    <= tf_d;
            pass_idx   <= pass_d;
            pass_end   <= pass_end_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

endmodule

// File: tb/tb_ntt_addr_gen_param.sv
// Bench for ntt_addr_gen_param: two instances (ISSUE_GAP 0 and 14) share stimulus; one is
// observed at a time and compared against an arithmetic reference of the address rules.
module tb_ntt_addr_gen_param;
    import ntt_pkg::*;

    localparam int LOGN = 8;
    localparam int N    = 256;
    localparam int NI   = N / 4;
    localparam int PG   = 4;
    localparam int IGB  = 14;

    logic clk = 1'b0;
    logic rst, start, addr_ready, sel;
    logic [1:0] mode;

    logic       va, pea, busya, donea, vb, peb, busyb, doneb;
    logic [7:0] a1a, a2a, b1a, b2a, a1b, a2b, b1b, b2b;
    logic [6:0] tfa, tfb;
    logic [3:0] pa, pb;

    logic       ov, ope, obusy, odone;
    logic [7:0] oa1, oa2, ob1, ob2;
    logic [6:0] otf;
    logic [3:0] op;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ntt_addr_gen_param #(.LOGN(LOGN), .ISSUE_GAP(0), .PASS_GAP(PG)) dut_a (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .addr_ready(addr_ready),
        .addr_valid(va), .radda1(a1a), .radda2(a2a), .raddb1(b1a), .raddb2(b2a),
        .tf_addr(tfa), .pass_idx(pa), .pass_end(pea), .busy(busya), .done(donea)
    );

    ntt_addr_gen_param #(.LOGN(LOGN), .ISSUE_GAP(IGB), .PASS_GAP(PG)) dut_b (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .addr_ready(addr_ready),
        .addr_valid(vb), .radda1(a1b), .radda2(a2b), .raddb1(b1b), .raddb2(b2b),
        .tf_addr(tfb), .pass_idx(pb), .pass_end(peb), .busy(busyb), .done(doneb)
    );

    always_comb begin
        if (sel) begin
            ov = vb; ope = peb; obusy = busyb; odone = doneb;
            oa1 = a1b; oa2 = a2b; ob1 = b1b; ob2 = b2b; otf = tfb; op = pb;
        end else begin
            ov = va; ope = pea; obusy = busya; odone = donea;
            oa1 = a1a; oa2 = a2a; ob1 = b1a; ob2 = b2a; otf = tfa; op = pa;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: stride d and group count G straight from the pass rules, div/mod by d
    function automatic void model(input logic [1:0] m, input int p, input int i,
                                  output int base, output int d, output int tf);
        int g, gc;
        if (m == MODE_IN || m == MODE_OUT) begin
            base = 4 * i; d = 1; tf = 0;
        end else begin
            if (m == MODE_NTT) begin
                d = (N / 4) >> p; gc = 1 << p;
            end else begin
                d = 1 << p; gc = N / (4 * d);
            end
            g    = i / d;
            base = g * 4 * d + i % d;
            tf   = (m == MODE_NTT) ? gc + g : 2 * gc - 1 - g;
        end
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, 32'(ov), 0);
        chk({tag, "_a1"}, 32'(oa1), 0);
        chk({tag, "_a2"}, 32'(oa2), 0);
        chk({tag, "_b1"}, 32'(ob1), 0);
        chk({tag, "_b2"}, 32'(ob2), 0);
        chk({tag, "_tf"}, 32'(otf), 0);
        chk({tag, "_pass"}, 32'(op), 0);
        chk({tag, "_pend"}, 32'(ope), 0);
        chk({tag, "_busy"}, 32'(obusy), 0);
        chk({tag, "_done"}, 32'(odone), 0);
    endtask

    // One operation: checks latency, idle gaps, every issue, stall stability and done/busy.
    task automatic run_op(input logic [1:0] m, input int igap, input bit rnd,
                          input int abort_p, input int poke_p);
        int np, base, dd, tf, idle, guard;
        bit r;
        np = (m == MODE_IN || m == MODE_OUT) ? 1 : LOGN - 1;
        @(negedge clk);
        mode = m; start = 1'b1; addr_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        mode  = 2'($urandom);
        for (int p = 0; p < np; p++) begin
            for (int i = 0; i < NI; i++) begin
                idle = 0;
                while (!ov && idle < 100) begin
                    addr_ready = rnd ? 1'($urandom) : 1'b1;
                    @(posedge clk);
                    @(negedge clk);
                    idle++;
                end
                chk("idle_gap", idle, (i == 0) ? ((p == 0) ? 0 : PG) : igap);
                if (p == abort_p && i == 10) begin
                    rst = 1'b1;
                    @(posedge clk);
                    @(negedge clk);
                    rst = 1'b0;
                    chk_reset("abort");
                    return;
                end
                model(m, p, i, base, dd, tf);
                guard = 0;
                do begin
                    chk("valid", 32'(ov), 1);
                    chk("a1", 32'(oa1), base);
                    chk("a2", 32'(oa2), base + dd);
                    chk("b1", 32'(ob1), base + 2 * dd);
                    chk("b2", 32'(ob2), base + 3 * dd);
                    chk("tf", 32'(otf), tf);
                    chk("pass_idx", 32'(op), p);
                    chk("pass_end", 32'(ope), (i == NI - 1) ? 1 : 0);
                    chk("busy", 32'(obusy), 1);
                    chk("done_early", 32'(odone), 0);
                    r = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                    addr_ready = r;
                    if (p == poke_p && i == 5 && guard == 0) begin
                        start = 1'b1;
                        mode  = MODE_INTT;
                    end
                    @(posedge clk);
                    @(negedge clk);
                    start = 1'b0;
                    guard++;
                end while (!r && guard < 50);
            end
        end
        chk("done", 32'(odone), 1);
        chk("done_busy", 32'(obusy), 1);
        chk("done_valid", 32'(ov), 0);
        @(posedge clk);
        @(negedge clk);
        chk("post_done", 32'(odone), 0);
        chk("post_busy", 32'(obusy), 0);
        chk("post_valid", 32'(ov), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = MODE_NTT; addr_ready = 1'b1; sel = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;

        run_op(MODE_NTT, 0, 1'b0, -1, 2);
        run_op(MODE_INTT, 0, 1'b0, -1, -1);
        run_op(MODE_IN, 0, 1'b0, -1, -1);
        run_op(MODE_OUT, 0, 1'b1, -1, -1);

        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sel = 1'b1;
        run_op(MODE_NTT, IGB, 1'b1, -1, -1);
        run_op(MODE_INTT, IGB, 1'b1, -1, -1);
        run_op(MODE_IN, IGB, 1'b1, -1, -1);

        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sel = 1'b0;
        run_op(MODE_NTT, 0, 1'b0, 3, -1);
        run_op(MODE_NTT, 0, 1'b1, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
